// File: rtl/caliptra_prim_util_pkg.sv
// caliptra_prim_util_pkg: shared elaboration helpers
package caliptra_prim_util_pkg;
  function automatic integer vbits(integer value);
    return (value == 1) ? 1 : $clog2(value);
  endfunction
endpackage

// File: rtl/prim_ram_1p_init_pkg.sv
// prim_ram_1p_init_pkg: init-engine state, parity sizing and init parity value
package prim_ram_1p_init_pkg;
  typedef enum logic {INIT, READY} ram_init_state_e;
  localparam logic ParityInitBit = 1'b1;
  function automatic int parity_w(int width, int en);
    return (en != 0) ? width / 8 : 0;
  endfunction
endpackage

// File: rtl/prim_ram_1p_pkg.sv
// prim_ram_1p_pkg: technology configuration passed through to the RAM macro
package prim_ram_1p_pkg;
  typedef struct packed {
    logic [3:0] ram_cfg;
    logic       cfg_en;
  } ram_1p_cfg_t;
endpackage

// File: rtl/prim_ram_1p.sv
// prim_ram_1p: generic single-port RAM with bit mask, registered read data
module prim_ram_1p
  import prim_ram_1p_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 128,
  localparam int Aw = caliptra_prim_util_pkg::vbits(Depth)
) (
  input  logic              clk_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [Aw-1:0]     addr_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic [Width-1:0]  wmask_i,
  output logic [Width-1:0]  rdata_o,
  input  ram_1p_cfg_t       cfg_i
);
  logic [Width-1:0] mem [Depth];
  logic unused_cfg;
  assign unused_cfg = ^cfg_i;
  always_ff @(posedge clk_i) begin
    if (req_i && write_i) mem[addr_i] <= (mem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
    else if (req_i) rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/prim_ram_parity_codec.sv
// prim_ram_parity_codec: byte/9-bit interleave, odd parity generation and per-byte check
module prim_ram_parity_codec
  import prim_ram_1p_init_pkg::*;
#(
  parameter int Width = 32,
  parameter int EnableParity = 1,
  localparam int Tw = Width + parity_w(Width, EnableParity)
) (
  input  logic [Width-1:0]   data_i,
  input  logic [Width/8-1:0] mask_i,
  input  logic [Width/8-1:0] inj_i,
  input  logic [Tw-1:0]      enc_i,
  output logic [Tw-1:0]      enc_o,
  output logic [Tw-1:0]      mask_o,
  output logic [Width-1:0]   data_o,
  output logic               err_o
);
  localparam int Bytes = Width / 8;
  if (Width % 8 != 0) begin : g_width_chk
    $error("Width must be a multiple of 8");
  end
  if (EnableParity != 0) begin : g_par
    logic [Bytes-1:0] byte_err;
    for (genvar b = 0; b < Bytes; b++) begin : g_byte
      assign enc_o[9*b +: 8]  = data_i[8*b +: 8];
      assign enc_o[9*b+8]     = ~^data_i[8*b +: 8] ^ inj_i[b];
      assign mask_o[9*b +: 9] = {9{mask_i[b]}};
      assign data_o[8*b +: 8] = enc_i[9*b +: 8];
      assign byte_err[b]      = ~^enc_i[9*b +: 9];
    end
    assign err_o = |byte_err;
  end else begin : g_nopar
    logic unused_inj;
    assign unused_inj = ^inj_i;
    for (genvar b = 0; b < Bytes; b++) begin : g_byte
      assign mask_o[8*b +: 8] = {8{mask_i[b]}};
    end
    assign enc_o  = data_i;
    assign data_o = enc_i;
    assign err_o  = 1'b0;
  end
endmodule

// File: rtl/prim_ram_1p_init_adv.sv
// prim_ram_1p_init_adv: parity RAM wrapper with byte enables, req/gnt, init engine, error counter.
// Optional I3C_RAM_ERR_INJECT_EN adds err_inj_i to corrupt stored parity on writes.
module prim_ram_1p_init_adv
  import prim_ram_1p_pkg::*;
  import prim_ram_1p_init_pkg::*;
#(
  parameter int Depth = 512,
  parameter int Width = 32,
  parameter int EnableParity = 1,
  parameter int EnableInputPipeline = 0,
  parameter int EnableOutputPipeline = 0,
  parameter int InitOnReset = 1,
  parameter int ErrCntWidth = 8,
  localparam int Aw = caliptra_prim_util_pkg::vbits(Depth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   init_req_i,
  output logic                   init_done_o,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   write_i,
  input  logic [Aw-1:0]          addr_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic [Width/8-1:0]     be_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   rvalid_o,
  output logic [1:0]             rerror_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  input  logic                   err_cnt_clr_i,
  input  ram_1p_cfg_t            cfg_i
`ifdef I3C_RAM_ERR_INJECT_EN
  ,input logic [Width/8-1:0]     err_inj_i
`endif
);
  localparam int Bytes = Width / 8;
  localparam int Tw = Width + parity_w(Width, EnableParity);
  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);
  ram_init_state_e state_q, state_d;
  logic [Aw-1:0] cnt_q, addr_s, addr_p;
  logic [Bytes-1:0] inj;
  logic init, oor, req_s, we_s, rd_s, req_p, we_p, rd_p, oor_p;
  logic [Tw-1:0] wenc, wmsk, wenc_p, wmsk_p, ram_rdata, unused_renc, unused_rmsk;
  logic [Width-1:0] rdec, unused_wdec, d_a, d_b, hold_q;
  logic unused_werr, rerr, rv_a, oor_a, e_a, rv_b, e_b;
  logic [ErrCntWidth-1:0] err_cnt_q;
`ifdef I3C_RAM_ERR_INJECT_EN
  assign inj = err_inj_i;
`else
  assign inj = '0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= (InitOnReset != 0) ? INIT : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (init && cnt_q != LastAddr) ? cnt_q + 1'b1 : '0;
    end
  end
  always_comb state_d = init ? ((cnt_q == LastAddr) ? READY : INIT) : (init_req_i ? INIT : READY);
  always_comb begin
    init        = state_q == INIT;
    init_done_o = state_q == READY && !rst_i;
    gnt_o       = req_i && state_q == READY && !init_req_i && !rst_i;
  end
  // Out-of-range requests are granted but never reach the array.
  assign oor   = 32'(addr_i) >= 32'(Depth);
  assign req_s = init || (gnt_o && !oor);
  assign we_s  = init || write_i;
  assign rd_s  = gnt_o && !write_i;
  assign addr_s = init ? cnt_q : addr_i;
  prim_ram_parity_codec #(.Width(Width), .EnableParity(EnableParity)) u_wcodec (
    .data_i(init ? '0 : wdata_i), .mask_i(init ? '1 : be_i), .inj_i(init ? '0 : inj),
    .enc_i('0), .enc_o(wenc), .mask_o(wmsk), .data_o(unused_wdec), .err_o(unused_werr));
  if (EnableInputPipeline != 0) begin : g_ipipe
    always_ff @(posedge clk_i) begin
      if (rst_i) {req_p, we_p, rd_p, oor_p, addr_p, wenc_p, wmsk_p} <= '0;
      else {req_p, we_p, rd_p, oor_p, addr_p, wenc_p, wmsk_p} <= {req_s, we_s, rd_s, oor, addr_s, wenc, wmsk};
    end
  end else begin : g_ibyp
    assign {req_p, we_p, rd_p, oor_p, addr_p, wenc_p, wmsk_p} = {req_s, we_s, rd_s, oor, addr_s, wenc, wmsk};
  end
  prim_ram_1p #(.Width(Tw), .Depth(Depth)) u_ram (
    .clk_i, .req_i(req_p), .write_i(we_p), .addr_i(addr_p), .wdata_i(wenc_p),
    .wmask_i(wmsk_p), .rdata_o(ram_rdata), .cfg_i);
  prim_ram_parity_codec #(.Width(Width), .EnableParity(EnableParity)) u_rcodec (
    .data_i('0), .mask_i('0), .inj_i('0), .enc_i(ram_rdata),
    .enc_o(unused_renc), .mask_o(unused_rmsk), .data_o(rdec), .err_o(rerr));
  always_ff @(posedge clk_i) begin
    if (rst_i) {rv_a, oor_a} <= '0;
    else {rv_a, oor_a} <= {rd_p, rd_p && oor_p};
  end
  assign d_a = oor_a ? '0 : rdec;
  assign e_a = rv_a && (oor_a || rerr);
  if (EnableOutputPipeline != 0) begin : g_opipe
    always_ff @(posedge clk_i) begin
      if (rst_i) {rv_b, e_b, d_b} <= '0;
      else {rv_b, e_b, d_b} <= {rv_a, e_a, d_a};
    end
  end else begin : g_obyp
    assign {rv_b, e_b, d_b} = {rv_a, e_a, d_a};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      hold_q    <= rv_b ? d_b : hold_q;
      err_cnt_q <= err_cnt_clr_i ? '0 : (e_b && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end
  end
  assign rvalid_o  = rv_b;
  assign rdata_o   = rv_b ? d_b : hold_q;
  assign rerror_o  = {e_b, 1'b0};
  assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_prim_ram_1p_init_adv.sv
// tb_prim_ram_1p_init_adv: directed scoreboard bench, Depth=12, both pipelines, 4-bit error counter
module tb_prim_ram_1p_init_adv;
  import prim_ram_1p_pkg::*;
  localparam int Depth = 12, Lat = 3, CntMax = 15;
  logic clk_i = 0, rst_i = 1, init_req_i = 0, req_i = 0, write_i = 0, err_cnt_clr_i = 0;
  logic [3:0] addr_i = 0, be_i = 0, inj = 0;
  logic [31:0] wdata_i = 0;
  logic init_done_o, gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0] rerror_o;
  logic [3:0] err_cnt_o;
  ram_1p_cfg_t cfg_i = '0;
  typedef struct {logic [31:0] d; logic e; int cyc;} exp_t;
  exp_t q[$];
  logic [31:0] mem_m [Depth];
  logic [3:0] bad_m [Depth];
  int cyc = 0, n_chk = 0, n_fail = 0, exp_cnt = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  prim_ram_1p_init_adv #(
    .Depth(Depth), .Width(32), .EnableParity(1), .EnableInputPipeline(1),
    .EnableOutputPipeline(1), .InitOnReset(1), .ErrCntWidth(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .init_req_i(init_req_i), .init_done_o(init_done_o),
    .req_i(req_i), .gnt_o(gnt_o), .write_i(write_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .be_i(be_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rerror_o(rerror_o),
    .err_cnt_o(err_cnt_o), .err_cnt_clr_i(err_cnt_clr_i), .cfg_i(cfg_i)
`ifdef I3C_RAM_ERR_INJECT_EN
    , .err_inj_i(inj)
`endif
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (rvalid_o) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL rvalid_spurious: observed rvalid 1 expected 0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("rdata", rdata_o, e.d);
        chk("rerror", 32'(rerror_o), e.e ? 32'd2 : 32'd0);
        chk("rlatency", cyc, e.cyc);
        if (e.e && !err_cnt_clr_i && exp_cnt < CntMax) exp_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(int a);
    exp_t e;
    req_i = 1; write_i = 0; addr_i = a[3:0];
    @(negedge clk_i);
    chk("gnt_rd", 32'(gnt_o), 1);
    e.d = 0; e.e = 1; e.cyc = cyc + Lat;
    if (a < Depth) begin
      e.d = mem_m[a];
      e.e = bad_m[a] != 0;
    end
    q.push_back(e);
    tick();
    req_i = 0;
  endtask

  task automatic wr(int a, logic [31:0] d, logic [3:0] be, logic [3:0] iv);
    req_i = 1; write_i = 1; addr_i = a[3:0]; wdata_i = d; be_i = be; inj = iv;
    @(negedge clk_i);
    chk("gnt_wr", 32'(gnt_o), 1);
    if (a < Depth)
      for (int b = 0; b < 4; b++)
        if (be[b]) begin
          mem_m[a][8*b +: 8] = d[8*b +: 8];
`ifdef I3C_RAM_ERR_INJECT_EN
          bad_m[a][b] = iv[b];
`else
          bad_m[a][b] = 1'b0;
`endif
        end
    tick();
    req_i = 0; write_i = 0; inj = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(q.size()), 0);
    tick();
  endtask

  task automatic wait_init(string tag);
    int n = 0;
    req_i = 1; write_i = 0; addr_i = 0;
    @(negedge clk_i);
    while (!init_done_o && n < 100) begin
      chk({tag, "_gnt"}, 32'(gnt_o), 0);
      n++;
      @(negedge clk_i);
    end
    req_i = 0;
    chk({tag, "_cycles"}, n, Depth);
    tick();
    for (int i = 0; i < Depth; i++) begin
      mem_m[i] = 0;
      bad_m[i] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < Depth; i++) begin
      mem_m[i] = 0;
      bad_m[i] = 0;
    end
    repeat (2) @(posedge clk_i);
    req_i = 1;
    @(negedge clk_i);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_init_done", 32'(init_done_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_rerror", 32'(rerror_o), 0);
    chk("rst_err_cnt", 32'(err_cnt_o), 0);
    tick();
    rst_i = 0; req_i = 0;
    wait_init("init_reset");
    for (int a = 0; a < 4; a++) rd(a);
    wr(2, 32'hDEADBEEF, 4'b0101, 4'b0);
    rd(2);
    drain();
    chk("be_merge_model", mem_m[2], 32'h00AD00EF);
    for (int a = 0; a < 8; a++) wr(a, 32'h01010101 * (a + 1) ^ $urandom, 4'hf, 4'b0);
    for (int a = 0; a < 8; a++) rd(a);
    drain();
    wr(3, 32'hCAFEF00D, 4'b1010, 4'b0);
    wr(4, 32'hFFFFFFFF, 4'b0000, 4'b0);
    rd(3);
    rd(4);
    drain();
    rd(13);
    drain();
    chk("err_cnt_oor", 32'(err_cnt_o), 32'(exp_cnt));
    wr(13, 32'hFFFFFFFF, 4'hf, 4'b0);
    for (int a = 0; a < Depth; a++) rd(a);
    rd(12);
    rd(15);
    drain();
    repeat (20) rd(13);
    drain();
    chk("err_cnt_sat", 32'(err_cnt_o), 32'(exp_cnt));
    err_cnt_clr_i = 1;
    rd(13);
    repeat (4) tick();
    err_cnt_clr_i = 0;
    exp_cnt = 0;
    drain();
    chk("err_cnt_clr", 32'(err_cnt_o), 0);
    rd(14);
    drain();
    chk("err_cnt_after_clr", 32'(err_cnt_o), 32'(exp_cnt));
`ifdef I3C_RAM_ERR_INJECT_EN
    wr(5, 32'h11223344, 4'hf, 4'b0010);
    repeat (3) rd(5);
    rd(6);
    drain();
    chk("err_cnt_inj", 32'(err_cnt_o), 32'(exp_cnt));
`endif
    rd(1);
    init_req_i = 1; req_i = 1; write_i = 0; addr_i = 0;
    @(negedge clk_i);
    chk("gnt_vs_init_req", 32'(gnt_o), 0);
    tick();
    init_req_i = 0;
    wait_init("reinit");
    for (int a = 0; a < Depth; a++) rd(a);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
